// File: rtl/obi_buffer.sv
// OBI buffer: FIFO buffering on both the A and R channels, with a credit
// counter that caps outstanding transactions so every response always
// has room in the R FIFO.
// Flat bus layout:
//   request  = {req, rready, a}  where a = {addr, we, be, wdata}
//   response = {gnt, rvalid, r}  where r = {rdata, err}
// Optional feature macro: OBI_BUFFER_STATS_EN adds the fill, credit and
// credit-stall counters as extra outputs.
module obi_buffer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter bit          UseRReady = 1'b1,
  parameter int unsigned ADepth    = 2,
  parameter int unsigned RDepth    = 2,
  parameter int unsigned MaxTxn    = RDepth,
  localparam int unsigned AChanW   = AddrWidth + 1 + DataWidth / 8 + DataWidth,
  localparam int unsigned RChanW   = DataWidth + 1,
  localparam int unsigned ReqW     = AChanW + 2,
  localparam int unsigned RspW     = RChanW + 2,
  localparam int unsigned AFillW   = $clog2(ADepth + 1),
  localparam int unsigned RFillW   = $clog2(RDepth + 1),
  localparam int unsigned CntW     = $clog2(MaxTxn + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [ReqW-1:0] sbr_port_req_i,
  output logic [RspW-1:0] sbr_port_rsp_o,
  output logic [ReqW-1:0] mgr_port_req_o,
  input  logic [RspW-1:0] mgr_port_rsp_i,
  output logic            r_overflow_o
`ifdef OBI_BUFFER_STATS_EN
  ,
  output logic [AFillW-1:0] a_fill_o,
  output logic [RFillW-1:0] r_fill_o,
  output logic [CntW-1:0]   txn_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int unsigned APtrW = (ADepth > 1) ? $clog2(ADepth) : 1;
  localparam int unsigned RPtrW = (RDepth > 1) ? $clog2(RDepth) : 1;

  if (MaxTxn < 1 || MaxTxn > RDepth) begin : g_bad_max_txn
    $error("obi_buffer: MaxTxn must lie within 1..RDepth");
  end
  if (ADepth < 1 || RDepth < 1) begin : g_bad_depth
    $error("obi_buffer: ADepth and RDepth must be at least 1");
  end

  logic              sbr_req, sbr_rready, mgr_gnt, mgr_rvalid;
  logic [AChanW-1:0] sbr_a;
  logic [RChanW-1:0] mgr_r;

  logic [AChanW-1:0] a_mem [ADepth];
  logic [APtrW-1:0]  a_wptr, a_rptr;
  logic [AFillW-1:0] a_fill;
  logic              a_full, a_empty, a_push, a_pop;

  logic [RChanW-1:0] r_mem [RDepth];
  logic [RPtrW-1:0]  r_wptr, r_rptr;
  logic [RFillW-1:0] r_fill;
  logic              r_full, r_empty, r_push, r_pop;

  logic [CntW-1:0]   cnt;
  logic              credit_ok, cnt_dec;
  logic              sbr_gnt, mgr_req, sbr_rvalid, mgr_rready;
  logic              overflow;

  function automatic logic [APtrW-1:0] a_next(input logic [APtrW-1:0] p);
    return (p == APtrW'(ADepth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RPtrW-1:0] r_next(input logic [RPtrW-1:0] p);
    return (p == RPtrW'(RDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign sbr_req    = sbr_port_req_i[ReqW-1];
  assign sbr_rready = sbr_port_req_i[ReqW-2];
  assign sbr_a      = sbr_port_req_i[AChanW-1:0];
  assign mgr_gnt    = mgr_port_rsp_i[RspW-1];
  assign mgr_rvalid = mgr_port_rsp_i[RspW-2];
  assign mgr_r      = mgr_port_rsp_i[RChanW-1:0];

  // Handshake qualification; reset forces gnt, req and rvalid low
  always_comb begin
    a_full     = (a_fill == AFillW'(ADepth));
    a_empty    = (a_fill == '0);
    r_full     = (r_fill == RFillW'(RDepth));
    r_empty    = (r_fill == '0);
    credit_ok  = (cnt < CntW'(MaxTxn));
    sbr_gnt    = !rst_i && !a_full;
    mgr_req    = !rst_i && !a_empty && credit_ok;
    sbr_rvalid = !rst_i && !r_empty;
    mgr_rready = UseRReady ? !r_full : 1'b1;
    a_push     = sbr_req && sbr_gnt;
    a_pop      = mgr_req && mgr_gnt;
    r_push     = !rst_i && mgr_rvalid && !r_full;
    r_pop      = sbr_rvalid && (UseRReady ? sbr_rready : 1'b1);
    // A response with no credit outstanding cannot return a credit
    cnt_dec    = r_pop && (cnt != '0);
  end

  assign sbr_port_rsp_o = {sbr_gnt, sbr_rvalid, r_mem[r_rptr]};
  assign mgr_port_req_o = {mgr_req, mgr_rready, a_mem[a_rptr]};
  assign r_overflow_o   = overflow;

  // A FIFO storage (no reset needed on data)
  always_ff @(posedge clk_i) begin
    if (a_push) a_mem[a_wptr] <= sbr_a;
  end

  // A FIFO pointers and fill level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_wptr <= '0;
      a_rptr <= '0;
      a_fill <= '0;
    end else begin
      if (a_push) a_wptr <= a_next(a_wptr);
      if (a_pop)  a_rptr <= a_next(a_rptr);
      if (a_push && !a_pop)      a_fill <= a_fill + 1'b1;
      else if (!a_push && a_pop) a_fill <= a_fill - 1'b1;
    end
  end

  // R FIFO storage
  always_ff @(posedge clk_i) begin
    if (r_push) r_mem[r_wptr] <= mgr_r;
  end

  // R FIFO pointers and fill level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (r_push) r_wptr <= r_next(r_wptr);
      if (r_pop)  r_rptr <= r_next(r_rptr);
      if (r_push && !r_pop)      r_fill <= r_fill + 1'b1;
      else if (!r_push && r_pop) r_fill <= r_fill - 1'b1;
    end
  end

  // Outstanding-transaction credits: up on downstream issue, down on upstream delivery
  always_ff @(posedge clk_i) begin
    if (rst_i)                cnt <= '0;
    else if (a_pop && !cnt_dec) cnt <= cnt + 1'b1;
    else if (!a_pop && cnt_dec) cnt <= cnt - 1'b1;
  end

  // Sticky flag for a response arriving with no R space
  always_ff @(posedge clk_i) begin
    if (rst_i)                      overflow <= 1'b0;
    else if (mgr_rvalid && r_full)  overflow <= 1'b1;
  end

`ifdef OBI_BUFFER_STATS_EN
  logic [31:0] stall_cnt;
  logic        credit_stall;

  assign credit_stall = !a_empty && (cnt == CntW'(MaxTxn));
  assign a_fill_o     = a_fill;
  assign r_fill_o     = r_fill;
  assign txn_cnt_o    = cnt;
  assign stall_cnt_o  = stall_cnt;

  // Saturating count of cycles where only the credit limit holds back req
  always_ff @(posedge clk_i) begin
    if (rst_i)                               stall_cnt <= '0;
    else if (credit_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_obi_buffer.sv
// Directed testbench for obi_buffer: one instance with rready honoured,
// one with rready ignored, both with 8-bit address/data, depth 2, MaxTxn 2.
module tb_obi_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance with UseRReady = 1
  logic        rr_req, rr_rready, rr_mgnt, rr_mrvalid, rr_ovf;
  logic [7:0]  rr_addr, rr_mrdata;
  logic [19:0] rr_sreq, rr_mreq;
  logic [10:0] rr_srsp, rr_mrsp;
  assign rr_sreq = {rr_req, rr_rready, rr_addr, 1'b0, 1'b1, 8'h00};
  assign rr_mrsp = {rr_mgnt, rr_mrvalid, rr_mrdata, 1'b0};

  // Instance with UseRReady = 0
  logic        nr_req, nr_rready, nr_mgnt, nr_mrvalid, nr_ovf;
  logic [7:0]  nr_addr, nr_mrdata;
  logic [19:0] nr_sreq, nr_mreq;
  logic [10:0] nr_srsp, nr_mrsp;
  assign nr_sreq = {nr_req, nr_rready, nr_addr, 1'b0, 1'b1, 8'h00};
  assign nr_mrsp = {nr_mgnt, nr_mrvalid, nr_mrdata, 1'b0};

`ifdef OBI_BUFFER_STATS_EN
  logic [1:0]  rr_afill, rr_rfill, rr_tcnt, nr_afill, nr_rfill, nr_tcnt;
  logic [31:0] rr_stall, nr_stall;
`endif

  obi_buffer #(
    .AddrWidth(8), .DataWidth(8), .UseRReady(1'b1),
    .ADepth(2), .RDepth(2), .MaxTxn(2)
  ) u_rr (
    .clk_i(clk), .rst_i(rst),
    .sbr_port_req_i(rr_sreq), .sbr_port_rsp_o(rr_srsp),
    .mgr_port_req_o(rr_mreq), .mgr_port_rsp_i(rr_mrsp),
    .r_overflow_o(rr_ovf)
`ifdef OBI_BUFFER_STATS_EN
    , .a_fill_o(rr_afill), .r_fill_o(rr_rfill), .txn_cnt_o(rr_tcnt), .stall_cnt_o(rr_stall)
`endif
  );

  obi_buffer #(
    .AddrWidth(8), .DataWidth(8), .UseRReady(1'b0),
    .ADepth(2), .RDepth(2), .MaxTxn(2)
  ) u_nr (
    .clk_i(clk), .rst_i(rst),
    .sbr_port_req_i(nr_sreq), .sbr_port_rsp_o(nr_srsp),
    .mgr_port_req_o(nr_mreq), .mgr_port_rsp_i(nr_mrsp),
    .r_overflow_o(nr_ovf)
`ifdef OBI_BUFFER_STATS_EN
    , .a_fill_o(nr_afill), .r_fill_o(nr_rfill), .txn_cnt_o(nr_tcnt), .stall_cnt_o(nr_stall)
`endif
  );

  wire       rr_gnt    = rr_srsp[10];
  wire       rr_rvalid = rr_srsp[9];
  wire [7:0] rr_rdata  = rr_srsp[8:1];
  wire       rr_mreq_v = rr_mreq[19];
  wire       rr_mrrdy  = rr_mreq[18];
  wire [7:0] rr_maddr  = rr_mreq[17:10];
  wire       nr_gnt    = nr_srsp[10];
  wire       nr_rvalid = nr_srsp[9];
  wire [7:0] nr_rdata  = nr_srsp[8:1];
  wire       nr_mreq_v = nr_mreq[19];

  int unsigned sent, got, a_in;
  logic        hs;

  initial begin
    rst = 1'b1;
    rr_req = 1'b0; rr_rready = 1'b0; rr_addr = '0; rr_mgnt = 1'b0;
    rr_mrvalid = 1'b1; rr_mrdata = 8'hEE;
    nr_req = 1'b0; nr_rready = 1'b0; nr_addr = '0; nr_mgnt = 1'b1;
    nr_mrvalid = 1'b0; nr_mrdata = '0;

    // Reset with a stray rvalid present: everything held low
    tick();
    check("rst_gnt", rr_gnt, 0);
    check("rst_rvalid", rr_rvalid, 0);
    tick();
    rst = 1'b0; rr_mrvalid = 1'b0;
    tick();
    check("idle_gnt", rr_gnt, 1);
    check("idle_req", rr_mreq_v, 0);
    check("idle_ovf", rr_ovf, 0);
    check("idle_rvalid", rr_rvalid, 0);

    // A buffering with downstream gnt low
    rr_rready = 1'b1; rr_req = 1'b1; rr_addr = 8'h10;
    tick();
    check("a_first_req", rr_mreq_v, 1);
    check("a_first_addr", rr_maddr, 8'h10);
    check("a_first_gnt", rr_gnt, 1);
    rr_addr = 8'h11;
    tick();
    check("a_full_gnt", rr_gnt, 0);
    check("a_full_addr", rr_maddr, 8'h10);
    rr_addr = 8'h12;
    tick();
    check("a_hold_gnt", rr_gnt, 0);
    check("a_hold_addr", rr_maddr, 8'h10);
    rr_mgnt = 1'b1;
    tick();
    check("a_issue1_addr", rr_maddr, 8'h11);
    check("a_issue1_gnt", rr_gnt, 1);
    tick();
    rr_req = 1'b0; rr_mrvalid = 1'b1; rr_mrdata = 8'hA0;
    check("credit_stall_req", rr_mreq_v, 0);
    tick();
    rr_mrvalid = 1'b0;
    check("r0_rvalid", rr_rvalid, 1);
    check("r0_rdata", rr_rdata, 8'hA0);
    check("r0_still_stalled", rr_mreq_v, 0);
    tick();
    check("third_req", rr_mreq_v, 1);
    check("third_addr", rr_maddr, 8'h12);
    check("r0_popped", rr_rvalid, 0);
    tick();
    check("third_done", rr_mreq_v, 0);
    rr_mrvalid = 1'b1; rr_mrdata = 8'hA1;
    tick();
    rr_mrdata = 8'hA2;
    check("r1_rdata", rr_rdata, 8'hA1);
    tick();
    rr_mrvalid = 1'b0;
    check("r2_rdata", rr_rdata, 8'hA2);
    tick();
    check("r_drained", rr_rvalid, 0);

    // R buffering with upstream rready low
    rr_req = 1'b1; rr_addr = 8'h20; rr_rready = 1'b0;
    tick();
    rr_addr = 8'h21;
    tick();
    rr_req = 1'b0;
    tick();
    rr_mrvalid = 1'b1; rr_mrdata = 8'h0A;
    tick();
    rr_mrdata = 8'h0B;
    tick();
    rr_mrvalid = 1'b0;
    check("rhold_rvalid", rr_rvalid, 1);
    check("rhold_rdata", rr_rdata, 8'h0A);
    check("rhold_rready", rr_mrrdy, 0);
    tick();
    check("rhold_stable", rr_rdata, 8'h0A);
    rr_rready = 1'b1;
    tick();
    check("rdeliver_b", rr_rdata, 8'h0B);
    check("rdeliver_b_valid", rr_rvalid, 1);
    tick();
    check("rdeliver_done", rr_rvalid, 0);
    check("rdeliver_rready", rr_mrrdy, 1);

    // Back-to-back traffic without rready; subordinate answers one cycle after issue
    sent = 0; got = 0; a_in = 0;
    for (int i = 0; i < 24; i++) begin
      hs = nr_mreq_v;
      if (nr_req && nr_gnt) a_in++;
      tick();
      nr_req  = (i < 12);
      nr_addr = 8'(i);
      nr_mrvalid = hs;
      nr_mrdata  = 8'(sent);
      if (hs) sent++;
      if (nr_rvalid) begin
        check("nr_order", nr_rdata, 8'(got));
        got++;
      end
    end
    check("nr_all_delivered", got, sent);
    check("nr_all_issued", sent, a_in);
    check("nr_ovf", nr_ovf, 0);

    // Forced overflow: third rvalid into a full R FIFO
    rr_rready = 1'b0; rr_mrvalid = 1'b1; rr_mrdata = 8'h55;
    tick();
    check("ovf_pre1", rr_ovf, 0);
    tick();
    check("ovf_pre2", rr_ovf, 0);
    tick();
    rr_mrvalid = 1'b0;
    check("ovf_set", rr_ovf, 1);
    tick();
    check("ovf_sticky", rr_ovf, 1);
    check("ovf_head", rr_rdata, 8'h55);

    // Reset with 2 A entries and 1 R entry buffered
    rr_rready = 1'b1; rr_mgnt = 1'b0; rr_req = 1'b1; rr_addr = 8'h30;
    tick();
    rr_rready = 1'b0; rr_addr = 8'h31;
    tick();
    rr_req = 1'b0;
    check("pre_rst_gnt", rr_gnt, 0);
    check("pre_rst_addr", rr_maddr, 8'h30);
    check("pre_rst_rvalid", rr_rvalid, 1);
    rst = 1'b1;
    #1;
    check("in_rst_gnt", rr_gnt, 0);
    check("in_rst_req", rr_mreq_v, 0);
    check("in_rst_rvalid", rr_rvalid, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_rvalid", rr_rvalid, 0);
    check("post_rst_req", rr_mreq_v, 0);
    check("post_rst_gnt", rr_gnt, 1);
    check("post_rst_ovf", rr_ovf, 0);
    rr_rready = 1'b1; rr_mgnt = 1'b1;
    tick();
    check("post_rst_rvalid2", rr_rvalid, 0);
    check("post_rst_req2", rr_mreq_v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
